trace_buf_ctrl: RTL
===================

TRACE_BUF_CTRL -- requirements
Module: trace_buf_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 16, trace buffer entries (power of two, 4..256).
REQ-002 SHALL have port clk, input, 1, sole clock.
REQ-003 SHALL have port rst, input, 1, synchronous reset, active-high.
REQ-004 SHALL have port cfg_en, input, 1, capture enable level.
REQ-005 SHALL have port cfg_prv_mask, input, 4, per-privilege capture enable; bit index = prv (0 U, 1 S, 2 H, 3 M).
REQ-006 SHALL have port cfg_trig_en, input, 1, arm on PC trigger before capturing.
REQ-007 SHALL have port cfg_trig_pc, input, 32, trigger PC.
REQ-008 SHALL have port cfg_stop_full, input, 1; 1 = freeze when full, 0 = overwrite oldest.
REQ-009 SHALL have port clr, input, 1, single-cycle flush pulse.
REQ-010 SHALL have ports ret_valid 1, ret_pc 32, ret_inst 32, ret_prv 2, ret_trap 1, all input, retired-instruction record.
REQ-011 SHALL have ports rd_valid output 1, rd_ready input 1, rd_pc output 32, rd_inst output 32, rd_prv output 2, rd_trap output 1, readout handshake.
REQ-012 SHALL have ports state output 2 (0 IDLE, 1 ARMED, 2 CAPTURE, 3 FROZEN), count output $clog2(DEPTH)+1, ovf output 1.

Function
REQ-013 SHALL treat a record as qualified when ret_valid=1 and cfg_prv_mask[ret_prv]=1.
REQ-014 IDLE SHALL go to ARMED if cfg_en=1 and cfg_trig_en=1, else to CAPTURE if cfg_en=1.
REQ-015 ARMED SHALL go to CAPTURE on a qualified record with ret_pc==cfg_trig_pc; that record SHALL be written in the same cycle.
REQ-016 CAPTURE SHALL write every qualified record at wr_ptr, then increment wr_ptr modulo DEPTH and count.
REQ-017 Qualified record when count==DEPTH, no pop, cfg_stop_full=1: record dropped, ovf set, next state FROZEN.
REQ-018 Qualified record when count==DEPTH, no pop, cfg_stop_full=0: oldest entry overwritten, rd_ptr advanced, count unchanged, ovf set.
REQ-019 FROZEN SHALL perform no writes; it leaves only via cfg_en=0.
REQ-020 cfg_en=0 SHALL force IDLE next cycle from any state; buffer contents, count and ovf retained.
REQ-021 rd_valid SHALL equal (count!=0); rd_* SHALL show entry at rd_ptr combinationally (first-word-fall-through).
REQ-022 rd_valid&&rd_ready SHALL pop: rd_ptr increments modulo DEPTH, count decrements; reads permitted in every state.
REQ-023 Simultaneous pop and write at full SHALL not overflow: count unchanged, ovf unchanged, no overwrite.
REQ-024 A write into an empty buffer SHALL become visible on rd_* the following cycle, never the same cycle.
REQ-025 clr SHALL reset wr_ptr, rd_ptr, count and ovf to 0, take priority over same-cycle write and pop, and leave state unchanged except FROZEN->CAPTURE when cfg_en=1.
REQ-026 count SHALL never exceed DEPTH; pointers SHALL wrap from DEPTH-1 to 0.

Reset
REQ-027 On rst=1 at posedge clk: state=IDLE, wr_ptr=0, rd_ptr=0, count=0, ovf=0, rd_valid=0; buffer RAM not cleared.
REQ-028 rst SHALL dominate clr, cfg_en, writes and pops in the same cycle; reset mid-capture discards all entries.

Configuration
REQ-029 With TRACE_TIMESTAMP_EN defined: 32-bit free-running cycle counter (reset 0, +1 per cycle, wraps), stored with each record, presented on extra output port rd_time 32.
REQ-030 Without TRACE_TIMESTAMP_EN: no counter, no rd_time port, all other behaviour identical.

Verification
REQ-031 Reset, cfg_en=1, trig off, mask=4'b1000, 3 M-mode retires pc 0x100/0x104/0x108 -> count=3, reads return 0x100,0x104,0x108 in order, then rd_valid=0.
REQ-032 cfg_trig_en=1, trig_pc=0x200, retires 0x1FC,0x200,0x204 -> state ARMED then CAPTURE; buffer holds 0x200,0x204 only.
REQ-033 DEPTH=16, cfg_stop_full=1, 17 qualified retires -> count=16, ovf=1, state=FROZEN, first read = 1st record.
REQ-034 DEPTH=16, cfg_stop_full=0, 20 retires pc 0..19*4 -> count=16, ovf=1, reads return pc 16..76 in order.
REQ-035 Full buffer, pop and qualified write same cycle -> count stays 16, ovf stays 0; U-mode retire with mask=4'b1000 -> not written.
REQ-036 clr and qualified write same cycle with count=5 -> count=0, ovf=0, rd_valid=0 next cycle; TRACE_TIMESTAMP_EN build: retires at cycles 10 and 13 after reset -> rd_time 10 then 13.

Source files
------------

// File: rtl/trace_buf_ctrl.sv
// trace_buf_ctrl: retired-instruction trace buffer controller.
//   Captures qualified retire records into a DEPTH-entry circular buffer and
//   presents the oldest entry on a first-word-fall-through readout port.
// Optional feature macro: TRACE_TIMESTAMP_EN -- adds a 32-bit free-running
//   cycle counter stored with each record and shown on rd_time.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   cfg_en                   capture enable level
//   cfg_prv_mask[3:0]        per-privilege capture enable (bit = prv)
//   cfg_trig_en, cfg_trig_pc arm on trigger PC before capturing
//   cfg_stop_full            1 = freeze when full, 0 = overwrite oldest
//   clr                      single-cycle flush pulse
//   ret_*                    retired-instruction record input
//   rd_valid/rd_ready, rd_*  readout handshake and oldest record
//   rd_time                  record timestamp (TRACE_TIMESTAMP_EN only)
//   state                    0 IDLE, 1 ARMED, 2 CAPTURE, 3 FROZEN
//   count, ovf               occupancy and sticky overflow flag
module trace_buf_ctrl #(
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cfg_en,
  input  logic [3:0]               cfg_prv_mask,
  input  logic                     cfg_trig_en,
  input  logic [31:0]              cfg_trig_pc,
  input  logic                     cfg_stop_full,
  input  logic                     clr,
  input  logic                     ret_valid,
  input  logic [31:0]              ret_pc,
  input  logic [31:0]              ret_inst,
  input  logic [1:0]               ret_prv,
  input  logic                     ret_trap,
  output logic                     rd_valid,
  input  logic                     rd_ready,
  output logic [31:0]              rd_pc,
  output logic [31:0]              rd_inst,
  output logic [1:0]               rd_prv,
  output logic                     rd_trap,
`ifdef TRACE_TIMESTAMP_EN
  output logic [31:0]              rd_time,
`endif
  output logic [1:0]               state,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     ovf
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    FROZEN  = 2'd3
  } state_t;

  typedef struct packed {
`ifdef TRACE_TIMESTAMP_EN
    logic [31:0] tstamp;
`endif
    logic [31:0] pc;
    logic [31:0] inst;
    logic [1:0]  prv;
    logic        trap;
  } entry_t;

  state_t        st;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] cnt;
  logic          ovf_q;
  entry_t        mem [DEPTH];
  entry_t        wr_entry;
  entry_t        rd_entry;

  logic qual, pop, full, trig_hit, cap, push, ovwr, drop, we;

`ifdef TRACE_TIMESTAMP_EN
  logic [31:0] tstamp;

  // Free-running cycle counter; wraps naturally at 2^32.
  always_ff @(posedge clk) begin
    if (rst) tstamp <= 32'd0;
    else     tstamp <= tstamp + 32'd1;
  end
`endif

  // Write qualification and full-buffer resolution.
  always_comb begin
    qual     = ret_valid && cfg_prv_mask[ret_prv];
    pop      = (cnt != '0) && rd_ready;
    full     = (cnt == FULL_CNT);
    trig_hit = (st == ARMED) && qual && (ret_pc == cfg_trig_pc);
    cap      = ((st == CAPTURE) && qual) || trig_hit;
    // A pop in the same cycle frees a slot, so a full buffer still accepts.
    push     = cap && (!full || pop);
    ovwr     = cap && full && !pop && !cfg_stop_full;
    drop     = cap && full && !pop && cfg_stop_full;
    we       = !rst && !clr && (push || ovwr);
  end

  always_comb begin
    wr_entry      = '0;
`ifdef TRACE_TIMESTAMP_EN
    wr_entry.tstamp = tstamp;
`endif
    wr_entry.pc   = ret_pc;
    wr_entry.inst = ret_inst;
    wr_entry.prv  = ret_prv;
    wr_entry.trap = ret_trap;
  end

  // Buffer RAM: no reset, contents survive rst and clr.
  always_ff @(posedge clk) begin
    if (we) mem[wr_ptr] <= wr_entry;
  end

  // Control FSM, pointers, occupancy and overflow flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      st     <= IDLE;
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      ovf_q  <= 1'b0;
    end else begin
      if (!cfg_en) begin
        st <= IDLE;
      end else if (clr) begin
        // Flush holds state, except that a frozen buffer resumes capture.
        if (st == FROZEN) st <= CAPTURE;
      end else begin
        unique case (st)
          IDLE:    st <= cfg_trig_en ? ARMED : CAPTURE;
          ARMED: begin
            if (drop)          st <= FROZEN;
            else if (trig_hit) st <= CAPTURE;
          end
          CAPTURE: if (drop) st <= FROZEN;
          FROZEN:  st <= FROZEN;
          default: st <= IDLE;
        endcase
      end

      if (clr) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        cnt    <= '0;
        ovf_q  <= 1'b0;
      end else begin
        if (push || ovwr) wr_ptr <= wr_ptr + AW'(1);
        // Overwrite retires the oldest entry by advancing the read side.
        if (pop || ovwr)  rd_ptr <= rd_ptr + AW'(1);
        if (push && !pop)      cnt <= cnt + CW'(1);
        else if (!push && pop) cnt <= cnt - CW'(1);
        if (ovwr || drop) ovf_q <= 1'b1;
      end
    end
  end

  // First-word-fall-through readout of the oldest entry.
  always_comb begin
    rd_entry = mem[rd_ptr];
    rd_valid = (cnt != '0);
    rd_pc    = rd_entry.pc;
    rd_inst  = rd_entry.inst;
    rd_prv   = rd_entry.prv;
    rd_trap  = rd_entry.trap;
`ifdef TRACE_TIMESTAMP_EN
    rd_time  = rd_entry.tstamp;
`endif
  end

  assign state = st;
  assign count = cnt;
  assign ovf   = ovf_q;

endmodule
